// File: rtl/ula_pkg.sv
// Shared definitions for the ALU sequencing driver.
//   OP_*    : opcode values understood by the ula ALU (others yield zero)
//   state_e : driver FSM states
package ula_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/ula_settle_counter.sv
// Loadable down-counter that times how long the ALU inputs settle.
//   clk, rst : clock, asynchronous active-high reset
//   load_i   : load SETTLE-1 (has priority over dec_i)
//   dec_i    : decrement while non-zero
//   done_o   : count has reached zero
module ula_settle_counter #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic dec_i,
  output logic done_o
);

  localparam int CNT_W = $clog2(SETTLE) + 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(SETTLE - 1);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/ula_driver.sv
// Sequencing initiator for the combinational ula ALU. Accepts a command,
// drives registered operands/opcode to the ALU, waits SETTLE cycles, captures
// the result into rsp_data and the accumulator, then offers it on a
// valid/ready response channel.
//   cmd_valid/cmd_ready, cmd_op, cmd_a_sel, cmd_a, cmd_b : command channel
//   alu_a, alu_b, alu_s (out), alu_out (in)              : ALU interface
//   rsp_valid/rsp_ready, rsp_data, rsp_zero              : response channel
//   acc  : accumulator (last captured result)
//   busy : a command is in flight
module ula_driver
  import ula_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int OP_W   = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic             cmd_a_sel,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_s,
  input  logic [WIDTH-1:0] alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] acc,
  output logic             busy
);

  state_e           state_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [OP_W-1:0]  alu_s_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_zero_q;
  logic [WIDTH-1:0] acc_q;
  logic             rsp_valid_q;
  logic             busy_q;

  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_done;

  assign cnt_load = (state_q == IDLE) && cmd_valid;
  assign cnt_dec  = (state_q == WAIT);

  ula_settle_counter #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk    (clk),
    .rst    (rst),
    .load_i (cnt_load),
    .dec_i  (cnt_dec),
    .done_o (cnt_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_s_q     <= '0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      acc_q       <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            // Accumulator chaining samples acc as it stands at acceptance.
            alu_a_q <= cmd_a_sel ? acc_q : cmd_a;
            alu_b_q <= cmd_b;
            alu_s_q <= cmd_op;
            busy_q  <= 1'b1;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_done) begin
            rsp_data_q  <= alu_out;
            acc_q       <= alu_out;
            rsp_zero_q  <= (alu_out == '0);
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // State decode only; asynchronous reset forces IDLE so this follows at once.
  assign cmd_ready = (state_q == IDLE);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_s     = alu_s_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign acc       = acc_q;
  assign busy      = busy_q;

endmodule
